// File: rtl/audio_play_ctrl_pkg.sv
// Shared types for the sound-out playback controller.
package audio_play_ctrl_pkg;

  localparam int unsigned SAMPLE_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_DRAIN = 2'd2
  } play_state_e;

  typedef struct packed {
    logic [SAMPLE_W-1:0] left;
    logic [SAMPLE_W-1:0] right;
  } stereo_frame_t;

endpackage

// File: rtl/audio_play_ctrl_frame_fifo.sv
// Synchronous stereo-frame FIFO with flush; a pop frees room for a same-cycle push.
module audio_frame_fifo
  import audio_play_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                push,
  input  stereo_frame_t       push_data,
  input  logic                pop,
  output stereo_frame_t       head_c,
  output logic [DEPTH_LOG2:0] count_nxt_c,
  output logic                full_c,
  output logic                empty_c
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned CNT_W = DEPTH_LOG2 + 1;

  stereo_frame_t         mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [CNT_W-1:0]      count;
  logic                  do_push;
  logic                  do_pop;

  assign full_c  = (count == CNT_W'(DEPTH));
  assign empty_c = (count == '0);
  assign head_c  = mem[rd_ptr];
  assign do_pop  = pop && !empty_c && !flush;
  assign do_push = push && !flush && (!full_c || do_pop);

  // Next occupancy, exposed so the owner can register level-based flags in step.
  always_comb begin
    count_nxt_c = count;
    if (flush) begin
      count_nxt_c = '0;
    end else if (do_push && !do_pop) begin
      count_nxt_c = count + CNT_W'(1);
    end else if (do_pop && !do_push) begin
      count_nxt_c = count - CNT_W'(1);
    end
  end

  // Pointer and count registers; pointers wrap naturally at the depth.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      count <= count_nxt_c;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
        if (do_pop)  rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
      end
    end
  end

  // Frame storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/audio_play_ctrl.sv
// Playback sequencer: pairs sample ops into stereo frames and releases them on DAC ticks.
module audio_play_ctrl
  import audio_play_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter int unsigned REQ_LOW    = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                audio_starts,
  input  logic                audio_22khz,
  input  logic                is_audio_sample,
  input  logic [SAMPLE_W-1:0] sample_data,
  input  logic                end_audio_sample,
  input  logic                all_1_packet,
  input  logic                frame_tick,
  output logic                out_valid,
  output logic [SAMPLE_W-1:0] out_left,
  output logic [SAMPLE_W-1:0] out_right,
  output logic                sample_req,
  output logic                playing,
  output logic                underrun,
  output logic                overflow
);

  localparam int unsigned CNT_W = DEPTH_LOG2 + 1;

  play_state_e         state_q, state_d;
  logic                rate22_q, rate22_d;
  logic                half_q, half_d;
  logic                rep_q, rep_d;
  logic [SAMPLE_W-1:0] left_hold_q, left_hold_d;
  logic [SAMPLE_W-1:0] out_left_d, out_right_d;
  logic                out_valid_d, underrun_d, overflow_d;
  logic                sample_req_d, playing_d;

  logic                fifo_flush, fifo_push, fifo_pop;
  stereo_frame_t       fifo_head, push_frame;
  logic [CNT_W-1:0]    fifo_count_nxt;
  logic                fifo_full, fifo_empty;

  assign push_frame = '{left: left_hold_q, right: sample_data};

  audio_frame_fifo #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (reset_n),
    .flush       (fifo_flush),
    .push        (fifo_push),
    .push_data   (push_frame),
    .pop         (fifo_pop),
    .head_c      (fifo_head),
    .count_nxt_c (fifo_count_nxt),
    .full_c      (fifo_full),
    .empty_c     (fifo_empty)
  );

  // Next state and outputs: abort first, then stream events, then the tick against the result.
  always_comb begin
    state_d     = state_q;
    rate22_d    = rate22_q;
    half_d      = half_q;
    rep_d       = rep_q;
    left_hold_d = left_hold_q;
    out_left_d  = out_left;
    out_right_d = out_right;
    out_valid_d = 1'b0;
    underrun_d  = 1'b0;
    overflow_d  = 1'b0;
    fifo_flush  = 1'b0;
    fifo_push   = 1'b0;
    fifo_pop    = 1'b0;

    if (all_1_packet) begin
      state_d     = ST_IDLE;
      fifo_flush  = 1'b1;
      half_d      = 1'b0;
      rep_d       = 1'b0;
      out_left_d  = '0;
      out_right_d = '0;
    end else begin
      if (audio_starts && (state_q != ST_DRAIN)) begin
        state_d    = ST_PLAY;
        rate22_d   = audio_22khz;
        fifo_flush = 1'b1;
        half_d     = 1'b0;
        rep_d      = 1'b0;
      end else if ((state_q == ST_PLAY) && end_audio_sample) begin
        state_d = ST_DRAIN;
        half_d  = 1'b0;
      end else if ((state_q == ST_PLAY) && is_audio_sample) begin
        if (half_q) begin
          fifo_push = 1'b1;
          half_d    = 1'b0;
        end else begin
          left_hold_d = sample_data;
          half_d      = 1'b1;
        end
      end

      // A flush in this cycle makes the FIFO look empty to the tick.
      if (frame_tick && (state_d != ST_IDLE)) begin
        if (rep_d) begin
          out_valid_d = 1'b1;
          rep_d       = 1'b0;
        end else if (!fifo_empty && !fifo_flush) begin
          fifo_pop    = 1'b1;
          out_left_d  = fifo_head.left;
          out_right_d = fifo_head.right;
          out_valid_d = 1'b1;
          rep_d       = rate22_d;
        end else if (state_d == ST_PLAY) begin
          out_left_d  = '0;
          out_right_d = '0;
          out_valid_d = 1'b1;
          underrun_d  = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end

      overflow_d = fifo_push && fifo_full && !fifo_pop;
    end
  end

  // Level outputs track the post-edge state and occupancy.
  assign sample_req_d = (state_d == ST_PLAY) && (fifo_count_nxt < CNT_W'(REQ_LOW));
  assign playing_d    = (state_d != ST_IDLE);

  // State, flags and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      rate22_q    <= 1'b0;
      half_q      <= 1'b0;
      rep_q       <= 1'b0;
      left_hold_q <= '0;
      out_valid   <= 1'b0;
      out_left    <= '0;
      out_right   <= '0;
      sample_req  <= 1'b0;
      playing     <= 1'b0;
      underrun    <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      state_q     <= state_d;
      rate22_q    <= rate22_d;
      half_q      <= half_d;
      rep_q       <= rep_d;
      left_hold_q <= left_hold_d;
      out_valid   <= out_valid_d;
      out_left    <= out_left_d;
      out_right   <= out_right_d;
      sample_req  <= sample_req_d;
      playing     <= playing_d;
      underrun    <= underrun_d;
      overflow    <= overflow_d;
    end
  end

endmodule

// File: tb/tb_audio_play_ctrl.sv
// Directed self-checking bench for audio_play_ctrl.
module tb_audio_play_ctrl;

  logic        clk;
  logic        reset_n;
  logic        audio_starts;
  logic        audio_22khz;
  logic        is_audio_sample;
  logic [15:0] sample_data;
  logic        end_audio_sample;
  logic        all_1_packet;
  logic        frame_tick;
  logic        out_valid;
  logic [15:0] out_left;
  logic [15:0] out_right;
  logic        sample_req;
  logic        playing;
  logic        underrun;
  logic        overflow;

  int n_cmp = 0;
  int n_bad = 0;

  audio_play_ctrl #(
    .DEPTH_LOG2(4),
    .REQ_LOW   (8)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .audio_starts     (audio_starts),
    .audio_22khz      (audio_22khz),
    .is_audio_sample  (is_audio_sample),
    .sample_data      (sample_data),
    .end_audio_sample (end_audio_sample),
    .all_1_packet     (all_1_packet),
    .frame_tick       (frame_tick),
    .out_valid        (out_valid),
    .out_left         (out_left),
    .out_right        (out_right),
    .sample_req       (sample_req),
    .playing          (playing),
    .underrun         (underrun),
    .overflow         (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts and reports.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the edge; outputs are read there too.
  task automatic step();
    @(posedge clk);
    #1;
    audio_starts     = 1'b0;
    is_audio_sample  = 1'b0;
    end_audio_sample = 1'b0;
    all_1_packet     = 1'b0;
    frame_tick       = 1'b0;
  endtask

  task automatic start(input logic r22);
    audio_starts = 1'b1;
    audio_22khz  = r22;
    step();
  endtask

  task automatic sample(input logic [15:0] d);
    is_audio_sample = 1'b1;
    sample_data     = d;
    step();
  endtask

  task automatic frame(input logic [15:0] l, input logic [15:0] r);
    sample(l);
    sample(r);
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    step();
  endtask

  // {out_valid, underrun, overflow, playing, sample_req}
  function automatic logic [4:0] flags();
    return {out_valid, underrun, overflow, playing, sample_req};
  endfunction

  initial begin
    reset_n          = 1'b0;
    audio_starts     = 1'b0;
    audio_22khz      = 1'b0;
    is_audio_sample  = 1'b0;
    sample_data      = '0;
    end_audio_sample = 1'b0;
    all_1_packet     = 1'b0;
    frame_tick       = 1'b0;
    repeat (3) step();
    check("reset_flags", 32'(flags()), 32'h0);
    check("reset_data", {out_left, out_right}, 32'h0);
    reset_n = 1'b1;
    step();

    // 44 kHz basic
    start(1'b0);
    check("start44_flags", 32'(flags()), 32'b00011);
    frame(16'h1111, 16'h2222);
    frame(16'h3333, 16'h4444);
    tick();
    check("b44_f1", {out_left, out_right}, 32'h11112222);
    check("b44_f1_flags", 32'(flags()), 32'b10011);
    tick();
    check("b44_f2", {out_left, out_right}, 32'h33334444);
    tick();
    check("b44_under_data", {out_left, out_right}, 32'h0);
    check("b44_under_flags", 32'(flags()), 32'b11011);
    step();
    check("b44_quiet", 32'(flags()), 32'b00011);

    // 22 kHz repeat
    start(1'b1);
    frame(16'hAAAA, 16'h5555);
    tick();
    check("r22_first", {out_left, out_right}, 32'hAAAA5555);
    check("r22_first_v", 32'(out_valid), 32'h1);
    tick();
    check("r22_repeat", {out_left, out_right}, 32'hAAAA5555);
    check("r22_repeat_flags", 32'(flags()), 32'b10011);
    tick();
    check("r22_under", {out_left, out_right}, 32'h0);
    check("r22_under_flags", 32'(flags()), 32'b11011);

    // Drain
    start(1'b0);
    for (int i = 1; i <= 3; i++) frame(16'h0100 + 16'(i), 16'h0200 + 16'(i));
    end_audio_sample = 1'b1;
    step();
    check("drain_enter", 32'(flags()), 32'b00010);
    for (int i = 1; i <= 3; i++) begin
      tick();
      check("drain_frame", {out_left, out_right}, {16'h0100 + 16'(i), 16'h0200 + 16'(i)});
      check("drain_flags", 32'(flags()), 32'b10010);
    end
    tick();
    check("drain_exit", 32'(flags()), 32'b00000);

    // Overflow and request level
    start(1'b0);
    for (int i = 1; i <= 17; i++) begin
      frame(16'(i), 16'h8000 | 16'(i));
      check("ovf_pulse", 32'(overflow), 32'(i == 17));
      if (i == 7) check("req_at7", 32'(sample_req), 32'h1);
      if (i == 8) check("req_at8", 32'(sample_req), 32'h0);
    end
    step();
    check("ovf_clear", 32'(overflow), 32'h0);
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (i == 1 || i == 16)
        check("ovf_drain", {out_left, out_right}, {16'(i), 16'h8000 | 16'(i)});
    end
    tick();
    check("ovf_count16", 32'(underrun), 32'h1);

    // Abort with tick and sample in the same cycle
    start(1'b0);
    frame(16'h1234, 16'h5678);
    tick();
    check("abort_pre", {out_left, out_right}, 32'h12345678);
    frame(16'h9999, 16'h8888);
    all_1_packet    = 1'b1;
    frame_tick      = 1'b1;
    is_audio_sample = 1'b1;
    sample_data     = 16'h7777;
    step();
    check("abort_flags", 32'(flags()), 32'b00000);
    check("abort_data", {out_left, out_right}, 32'h0);
    tick();
    check("abort_idle_tick", 32'(flags()), 32'b00000);

    // Half frame then restart at 22 kHz
    start(1'b0);
    sample(16'hDEAD);
    start(1'b1);
    frame(16'h0102, 16'h0304);
    tick();
    check("half_frame", {out_left, out_right}, 32'h01020304);
    tick();
    check("half_repeat", {out_left, out_right}, 32'h01020304);
    check("half_repeat_v", 32'(out_valid), 32'h1);

    // Restart together with a tick: the flush leaves nothing to pop
    frame(16'h4242, 16'h2424);
    audio_starts = 1'b1;
    audio_22khz  = 1'b0;
    frame_tick   = 1'b1;
    step();
    check("restart_tick", 32'(flags()), 32'b11011);

    // Reset mid-stream drops queued frames
    frame(16'h5151, 16'h1515);
    reset_n = 1'b0;
    step();
    check("midreset_flags", 32'(flags()), 32'b00000);
    reset_n = 1'b1;
    tick();
    check("midreset_tick", 32'(flags()), 32'b00000);
    check("midreset_data", {out_left, out_right}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
